position_tracker: RTL and testbench

Upstream producer of the processor's position state. It accepts decoded motion and mode commands, resolves absolute/relative targets, and issues one move at a time to the motor stage. It commits the new position only after the motor stage reports completion, then drives `cur_x`, `cur_y` and `is_absolute` on a `PositionState_IF.master` for downstream consumers.

---
 rtl/position_tracker_if.sv | 19 +
 rtl/position_tracker.sv | 152 +++++++++++++++
 tb/tb_position_tracker.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/position_tracker_if.sv
// Position state bundle shared between the tracker (master) and its consumers.
`ifndef POS_X_BITS
`define POS_X_BITS 16
`endif
`ifndef POS_Y_BITS
`define POS_Y_BITS 16
`endif

interface PositionState_IF #(
    parameter int POS_X_BITS = `POS_X_BITS,
    parameter int POS_Y_BITS = `POS_Y_BITS
);
    logic [POS_X_BITS-1:0] cur_x;
    logic [POS_Y_BITS-1:0] cur_y;
    logic                  is_absolute;

    modport master (output cur_x, output cur_y, output is_absolute);
    modport slave  (input cur_x, input cur_y, input is_absolute);
endinterface

// File: rtl/position_tracker.sv
// Resolves motion/mode commands into single outstanding moves and commits the
// new position once the motor stage reports completion.
`ifndef POS_X_BITS
`define POS_X_BITS 16
`endif
`ifndef POS_Y_BITS
`define POS_Y_BITS 16
`endif

module position_tracker #(
    parameter int POS_X_BITS = `POS_X_BITS,
    parameter int POS_Y_BITS = `POS_Y_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [POS_X_BITS-1:0] cmd_x,
    input  logic [POS_Y_BITS-1:0] cmd_y,
    output logic                  move_valid,
    input  logic                  move_ready,
    output logic [POS_X_BITS:0]   move_dx,
    output logic [POS_Y_BITS:0]   move_dy,
    input  logic                  move_done,
    PositionState_IF.master       pos_state
);
    localparam int N = POS_X_BITS;
    localparam int M = POS_Y_BITS;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam logic [2:0] OP_MOVE    = 3'd0;
    localparam logic [2:0] OP_SET_ABS = 3'd1;
    localparam logic [2:0] OP_SET_REL = 3'd2;
    localparam logic [2:0] OP_SET_POS = 3'd3;
    localparam logic [2:0] OP_HOME    = 3'd4;

    logic [1:0]   state_q, state_d;
    logic         is_abs_q, is_abs_d;
    logic [N-1:0] cur_x_q, cur_x_d, tgt_x_q, tgt_x_d;
    logic [M-1:0] cur_y_q, cur_y_d, tgt_y_q, tgt_y_d;
    logic [N:0]   dx_q, dx_d;
    logic [M:0]   dy_q, dy_d;

    logic signed [N+1:0] rel_x;
    logic signed [M+1:0] rel_y;
    logic [N-1:0] tx;
    logic [M-1:0] ty;
    logic [N:0]   new_dx;
    logic [M:0]   new_dy;

    // Relative sums carry two guard bits so cur + positive offset near the top
    // of range cannot wrap into the negative half before saturation.
    always_comb begin
        rel_x = $signed({2'b00, cur_x_q}) + $signed({{2{cmd_x[N-1]}}, cmd_x});
        rel_y = $signed({2'b00, cur_y_q}) + $signed({{2{cmd_y[M-1]}}, cmd_y});
        if (cmd_op == OP_HOME) begin
            tx = '0;
            ty = '0;
        end else if (is_abs_q) begin
            tx = cmd_x;
            ty = cmd_y;
        end else begin
            if (rel_x < 0)                                tx = '0;
            else if (rel_x > $signed({2'b00, {N{1'b1}}})) tx = '1;
            else                                          tx = rel_x[N-1:0];
            if (rel_y < 0)                                ty = '0;
            else if (rel_y > $signed({2'b00, {M{1'b1}}})) ty = '1;
            else                                          ty = rel_y[M-1:0];
        end
        new_dx = {1'b0, tx} - {1'b0, cur_x_q};
        new_dy = {1'b0, ty} - {1'b0, cur_y_q};
    end

    always_comb begin
        state_d  = state_q;
        is_abs_d = is_abs_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        tgt_x_d  = tgt_x_q;
        tgt_y_d  = tgt_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_MOVE, OP_HOME: begin
                            tgt_x_d = tx;
                            tgt_y_d = ty;
                            dx_d    = new_dx;
                            dy_d    = new_dy;
                            if ((new_dx != '0) || (new_dy != '0)) state_d = ST_ISSUE;
                        end
                        OP_SET_ABS: is_abs_d = 1'b1;
                        OP_SET_REL: is_abs_d = 1'b0;
                        OP_SET_POS: begin
                            cur_x_d = cmd_x;
                            cur_y_d = cmd_y;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ISSUE: begin
                if (move_ready) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (move_done) begin
                    cur_x_d = tgt_x_q;
                    cur_y_d = tgt_y_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            is_abs_q <= 1'b1;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            tgt_x_q  <= '0;
            tgt_y_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
        end else begin
            state_q  <= state_d;
            is_abs_q <= is_abs_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            tgt_x_q  <= tgt_x_d;
            tgt_y_q  <= tgt_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
        end
    end

    assign cmd_ready             = (state_q == ST_IDLE);
    assign move_valid            = (state_q == ST_ISSUE);
    assign move_dx               = dx_q;
    assign move_dy               = dy_q;
    assign pos_state.cur_x       = cur_x_q;
    assign pos_state.cur_y       = cur_y_q;
    assign pos_state.is_absolute = is_abs_q;

endmodule

// File: tb/tb_position_tracker.sv
// Directed + randomized bench for position_tracker against a plain-integer model.
module tb_position_tracker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [15:0] cmd_x = '0;
    logic [15:0] cmd_y = '0;
    logic        move_valid;
    logic        move_ready = 1'b0;
    logic [16:0] move_dx;
    logic [16:0] move_dy;
    logic        move_done = 1'b0;

    PositionState_IF #(.POS_X_BITS(16), .POS_Y_BITS(16)) ps ();

    position_tracker #(.POS_X_BITS(16), .POS_Y_BITS(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y),
        .move_valid(move_valid), .move_ready(move_ready),
        .move_dx(move_dx), .move_dy(move_dy), .move_done(move_done),
        .pos_state(ps)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    // reference model state
    int m_x = 0, m_y = 0;
    bit m_abs = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int target(input int op, input int a, input int cur);
        int s;
        if (op == 4) return 0;
        if (m_abs) return a;
        s = cur + ((a >= 32768) ? a - 65536 : a);
        if (s < 0) return 0;
        if (s > 65535) return 65535;
        return s;
    endfunction

    task automatic chk_pos(input string tag);
        chk({tag, ".cur_x"}, 32'(ps.cur_x), 32'(m_x));
        chk({tag, ".cur_y"}, 32'(ps.cur_y), 32'(m_y));
        chk({tag, ".abs"}, 32'(ps.is_absolute), 32'(m_abs));
    endtask

    // Non-move command; entered and left on a falling edge.
    task automatic simple_cmd(input int op, input int a, input int b);
        cmd_valid = 1'b1; cmd_op = 3'(op); cmd_x = 16'(a); cmd_y = 16'(b);
        chk("simple.ready_pre", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        case (op)
            1: m_abs = 1'b1;
            2: m_abs = 1'b0;
            3: begin m_x = a; m_y = b; end
            default: ;
        endcase
        chk_pos("simple");
        chk("simple.ready", 32'(cmd_ready), 32'd1);
        chk("simple.valid", 32'(move_valid), 32'd0);
    endtask

    task automatic run_move(input int op, input int a, input int b,
                            input int rdly, input int ddly, input bit noise);
        int tx, ty, cyc;
        logic [16:0] edx, edy;
        tx = target(op, a, m_x);
        ty = target(op, b, m_y);
        edx = 17'(tx - m_x);
        edy = 17'(ty - m_y);
        cmd_valid = 1'b1; cmd_op = 3'(op); cmd_x = 16'(a); cmd_y = 16'(b);
        move_ready = 1'b0; move_done = 1'b0;
        chk("move.ready_pre", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        chk("move.dx", 32'(move_dx), 32'(edx));
        chk("move.dy", 32'(move_dy), 32'(edy));
        if (tx == m_x && ty == m_y) begin
            chk("zero.valid", 32'(move_valid), 32'd0);
            chk("zero.ready", 32'(cmd_ready), 32'd1);
            chk_pos("zero");
            return;
        end
        chk("issue.valid", 32'(move_valid), 32'd1);
        chk("issue.ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < rdly; i++) begin
            if (noise) begin
                cmd_valid = 1'b1; cmd_op = 3'($urandom_range(0, 7));
                cmd_x = 16'($urandom); cmd_y = 16'($urandom);
                move_done = (i == 0);
            end
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0; move_done = 1'b0;
            chk("bp.valid", 32'(move_valid), 32'd1);
            chk("bp.dx", 32'(move_dx), 32'(edx));
            chk("bp.dy", 32'(move_dy), 32'(edy));
            chk("bp.ready", 32'(cmd_ready), 32'd0);
            chk_pos("bp");
        end
        move_ready = 1'b1;
        move_done = noise;
        @(negedge clk);
        cyc++;
        move_ready = 1'b0; move_done = 1'b0;
        chk("wait.valid", 32'(move_valid), 32'd0);
        chk("wait.ready", 32'(cmd_ready), 32'd0);
        chk_pos("wait");
        for (int i = 0; i < ddly; i++) begin
            @(negedge clk);
            cyc++;
            chk("wait2.ready", 32'(cmd_ready), 32'd0);
            chk_pos("wait2");
        end
        move_done = 1'b1;
        @(negedge clk);
        cyc++;
        move_done = 1'b0;
        m_x = tx; m_y = ty;
        chk_pos("commit");
        chk("commit.ready", 32'(cmd_ready), 32'd1);
        if (rdly == 0 && ddly == 0) chk("turnaround", 32'(cyc), 32'd3);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_pos("reset");
        chk("reset.ready", 32'(cmd_ready), 32'd1);
        chk("reset.valid", 32'(move_valid), 32'd0);
        chk("reset.dx", 32'(move_dx), 32'd0);

        // async reset while waiting for the motor stage
        simple_cmd(2, 0, 0);
        simple_cmd(3, 7, 9);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_x = 16'd3; cmd_y = 16'd3; move_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        move_ready = 1'b0;
        chk("pre_rst.ready", 32'(cmd_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        m_x = 0; m_y = 0; m_abs = 1'b1;
        chk_pos("async_rst");
        chk("async_rst.ready", 32'(cmd_ready), 32'd1);
        chk("async_rst.valid", 32'(move_valid), 32'd0);
        chk("async_rst.dx", 32'(move_dx), 32'd0);
        chk("async_rst.dy", 32'(move_dy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_pos("post_rst");

        run_move(0, 100, 200, 0, 0, 1'b0);
        simple_cmd(2, 0, 0);
        run_move(0, 16'hFFE2, 5, 0, 0, 1'b0);
        chk("rel.x70", 32'(ps.cur_x), 32'd70);
        run_move(0, 16'hFF9C, 0, 0, 0, 1'b0);
        chk("sat_lo.x", 32'(ps.cur_x), 32'd0);
        simple_cmd(3, 65530, 0);
        run_move(0, 10, 0, 0, 0, 1'b0);
        chk("sat_hi.x", 32'(ps.cur_x), 32'd65535);
        simple_cmd(1, 0, 0);
        run_move(0, 300, 400, 5, 1, 1'b1);
        simple_cmd(3, 500, 600);
        run_move(0, 500, 600, 0, 0, 1'b0);
        run_move(4, 1234, 4321, 0, 0, 1'b0);
        simple_cmd(6, 11, 22);

        for (int k = 0; k < 60; k++) begin
            int op, a, b;
            op = $urandom_range(0, 7);
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(65500, 65535)) : int'($urandom_range(0, 65535));
            b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 65535));
            if (op == 0 || op == 4)
                run_move(op, a, b, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            else
                simple_cmd(op, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
